// File: rtl/led_fill_sequencer.sv
// rtl/led_fill_sequencer.sv - 16-LED fill bar sequencer with tick-enable scheduler
//
// Purpose: arms, advances and wraps a growing fill mask on a 16-LED bar from a
// programmable start position. It runs entirely in the clk domain. A tick-enable
// counter sets the step rate, so no derived slow clock is needed.
//
// Ports:
//   clk        - system clock (only clock)
//   rst        - synchronous active-high reset
//   start      - arms or re-arms a sequence (level or pulse)
//   stop       - returns to IDLE; wins over start
//   speed_sel  - 0: TICK_SLOW cycles per step, 1: TICK_FAST (sampled live)
//   step_sel   - 0: +1 LED per tick, 1: +2 (latched at arm)
//   invert     - 1: extinguish mode, lit LEDs drive 0 (latched at arm)
//   start_pos  - first LED of the fill (latched at arm)
//   led        - registered LED drive
//   head       - registered index of the last lit LED
//   busy       - high in RUN or FULL
//   wrap_pulse - one-cycle pulse when the fill restarts after FULL
module led_fill_sequencer #(
    parameter int unsigned TICK_SLOW = 100_000_000,
    parameter int unsigned TICK_FAST = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        speed_sel,
    input  logic        step_sel,
    input  logic        invert,
    input  logic [3:0]  start_pos,
    output logic [15:0] led,
    output logic [3:0]  head,
    output logic        busy,
    output logic        wrap_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] tick_cnt_q, tick_cnt_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [3:0]  init_pos_q, init_pos_d;
    logic        step_q, step_d;
    logic        inv_l_q, inv_l_d;
    logic [15:0] led_q, led_d;
    logic [3:0]  head_q, head_d;
    logic        busy_q, busy_d;
    logic        wrap_q, wrap_d;

    logic [31:0] limit;
    logic        tick;
    logic [5:0]  cnt_next;
    logic [16:0] one_sh;
    logic [15:0] base_mask;
    logic [31:0] rot;
    logic [15:0] mask;

    // The comparison uses >= rather than ==. A live speed change that drops the limit
    // below the current count then fires at once, instead of the counter running
    // past the limit and never matching.
    assign limit = speed_sel ? 32'(TICK_FAST) : 32'(TICK_SLOW);
    assign tick  = (tick_cnt_q >= (limit - 32'd1));

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        cnt_d      = cnt_q;
        init_pos_d = init_pos_q;
        step_d     = step_q;
        inv_l_d    = inv_l_q;
        wrap_d     = 1'b0;
        cnt_next   = 6'(cnt_q) + (step_q ? 6'd2 : 6'd1);

        if (state_q != ST_IDLE) begin
            tick_cnt_d = tick ? 32'd0 : tick_cnt_q + 32'd1;
        end

        if (stop) begin
            state_d    = ST_IDLE;
            cnt_d      = 5'd0;
            tick_cnt_d = 32'd0;
        end else if (start) begin
            // Arm from any state: every setting is re-latched and the tick phase restarts.
            state_d    = ST_RUN;
            init_pos_d = start_pos;
            step_d     = step_sel;
            inv_l_d    = invert;
            cnt_d      = 5'd1;
            tick_cnt_d = 32'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (tick) begin
                        // Step 2 from 15 saturates at 16 rather than reaching 17.
                        if (cnt_next >= 6'd16) begin
                            cnt_d   = 5'd16;
                            state_d = ST_FULL;
                        end else begin
                            cnt_d = cnt_next[4:0];
                        end
                    end
                end
                ST_FULL: begin
                    if (tick) begin
                        cnt_d   = 5'd1;
                        wrap_d  = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    cnt_d = 5'd0;
                end
            endcase
        end
    end

    // Build the mask from the next state so that the registered outputs move on the
    // same edge as the state. The low cnt bits are set, then the two concatenated
    // copies are rotated left by init_pos. This produces the wrap from LED 15 to LED 0.
    always_comb begin
        one_sh    = 17'd1 << cnt_d;
        base_mask = 16'(one_sh - 17'd1);
        rot       = {base_mask, base_mask} << init_pos_d;
        mask      = rot[31:16];
        busy_d    = (state_d != ST_IDLE);
        if (state_d == ST_IDLE) begin
            led_d  = {16{invert}};
            head_d = 4'd0;
        end else begin
            led_d  = inv_l_d ? ~mask : mask;
            head_d = init_pos_d + cnt_d[3:0] - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= 32'd0;
            cnt_q      <= 5'd0;
            init_pos_q <= 4'd0;
            step_q     <= 1'b0;
            inv_l_q    <= 1'b0;
            led_q      <= 16'h0000;
            head_q     <= 4'd0;
            busy_q     <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            cnt_q      <= cnt_d;
            init_pos_q <= init_pos_d;
            step_q     <= step_d;
            inv_l_q    <= inv_l_d;
            led_q      <= led_d;
            head_q     <= head_d;
            busy_q     <= busy_d;
            wrap_q     <= wrap_d;
        end
    end

    assign led        = led_q;
    assign head       = head_q;
    assign busy       = busy_q;
    assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_led_fill_sequencer.sv
// tb/tb_led_fill_sequencer.sv - directed self-checking bench for led_fill_sequencer
module tb_led_fill_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        speed_sel = 1'b0;
    logic        step_sel = 1'b0;
    logic        invert = 1'b0;
    logic [3:0]  start_pos = 4'd0;
    logic [15:0] led;
    logic [3:0]  head;
    logic        busy;
    logic        wrap_pulse;

    int total = 0;
    int bad = 0;

    led_fill_sequencer #(.TICK_SLOW(4), .TICK_FAST(2)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .speed_sel(speed_sel),
        .step_sel(step_sel), .invert(invert), .start_pos(start_pos),
        .led(led), .head(head), .busy(busy), .wrap_pulse(wrap_pulse)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic arm(input logic [3:0] pos, input logic stp, input logic inv, input logic spd);
        start_pos = pos; step_sel = stp; invert = inv; speed_sel = spd;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1;
        cyc(2);
        total++; if (led !== 16'h0000) begin bad++; $display("FAIL reset_led got=%h exp=0000", led); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (wrap_pulse !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b exp=0", wrap_pulse); end
        total++; if (head !== 4'd0) begin bad++; $display("FAIL reset_head got=%0d exp=0", head); end
        rst = 1'b0; start = 1'b0;
        cyc(3);
        total++; if (led !== 16'h0000 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_stay_idle got led=%h busy=%b exp led=0000 busy=0", led, busy);
        end
    endtask

    task automatic test_fill_step1;
        arm(4'd3, 1'b0, 1'b0, 1'b0);
        total++; if (led !== 16'h0008 || busy !== 1'b1 || head !== 4'd3) begin
            bad++; $display("FAIL s1_arm got led=%h busy=%b head=%0d exp 0008 1 3", led, busy, head);
        end
        cyc(3);
        total++; if (led !== 16'h0008) begin bad++; $display("FAIL s1_hold got=%h exp=0008", led); end
        cyc(1);
        total++; if (led !== 16'h0018 || head !== 4'd4) begin
            bad++; $display("FAIL s1_tick1 got led=%h head=%0d exp 0018 4", led, head);
        end
        cyc(4);
        total++; if (led !== 16'h0038) begin bad++; $display("FAIL s1_tick2 got=%h exp=0038", led); end
        cyc(13 * 4);
        total++; if (led !== 16'hFFFF || head !== 4'd2 || wrap_pulse !== 1'b0) begin
            bad++; $display("FAIL s1_full got led=%h head=%0d wrap=%b exp FFFF 2 0", led, head, wrap_pulse);
        end
        cyc(3);
        total++; if (led !== 16'hFFFF || wrap_pulse !== 1'b0) begin
            bad++; $display("FAIL s1_full_hold got led=%h wrap=%b exp FFFF 0", led, wrap_pulse);
        end
        cyc(1);
        total++; if (led !== 16'h0008 || wrap_pulse !== 1'b1) begin
            bad++; $display("FAIL s1_wrap got led=%h wrap=%b exp 0008 1", led, wrap_pulse);
        end
        cyc(1);
        total++; if (wrap_pulse !== 1'b0) begin bad++; $display("FAIL s1_wrap_one_cycle got=%b exp=0", wrap_pulse); end
    endtask

    task automatic test_fill_step2;
        logic [15:0] exp_tab [0:8];
        exp_tab = '{16'h4000, 16'hC001, 16'hC007, 16'hC01F, 16'hC07F,
                    16'hC1FF, 16'hC7FF, 16'hDFFF, 16'hFFFF};
        arm(4'd14, 1'b1, 1'b0, 1'b1);
        total++; if (led !== exp_tab[0]) begin bad++; $display("FAIL s2_step0 got=%h exp=%h", led, exp_tab[0]); end
        for (int i = 1; i < 9; i++) begin
            cyc(2);
            total++; if (led !== exp_tab[i]) begin
                bad++; $display("FAIL s2_step%0d got=%h exp=%h", i, led, exp_tab[i]);
            end
        end
        total++; if (head !== 4'd13) begin bad++; $display("FAIL s2_full_head got=%0d exp=13", head); end
        cyc(2);
        total++; if (led !== 16'h4000 || wrap_pulse !== 1'b1 || head !== 4'd14) begin
            bad++; $display("FAIL s2_wrap got led=%h wrap=%b head=%0d exp 4000 1 14", led, wrap_pulse, head);
        end
    endtask

    task automatic test_invert;
        stop = 1'b1; cyc(1); stop = 1'b0;
        invert = 1'b1; speed_sel = 1'b0;
        cyc(1);
        total++; if (led !== 16'hFFFF || busy !== 1'b0) begin
            bad++; $display("FAIL inv_idle got led=%h busy=%b exp FFFF 0", led, busy);
        end
        arm(4'd0, 1'b0, 1'b1, 1'b0);
        total++; if (led !== 16'hFFFE) begin bad++; $display("FAIL inv_arm got=%h exp=FFFE", led); end
        cyc(4);
        total++; if (led !== 16'hFFFC) begin bad++; $display("FAIL inv_tick got=%h exp=FFFC", led); end
        stop = 1'b1; invert = 1'b0;
        cyc(1);
        total++; if (led !== 16'h0000 || busy !== 1'b0) begin
            bad++; $display("FAIL inv_stop got led=%h busy=%b exp 0000 0", led, busy);
        end
        stop = 1'b0; invert = 1'b1;
        cyc(1);
        total++; if (led !== 16'hFFFF) begin bad++; $display("FAIL inv_follow got=%h exp=FFFF", led); end
        invert = 1'b0;
        cyc(1);
    endtask

    task automatic test_stop_start;
        arm(4'd5, 1'b0, 1'b0, 1'b0);
        cyc(2);
        stop = 1'b1; start = 1'b1; start_pos = 4'd9;
        cyc(1);
        total++; if (led !== 16'h0000 || busy !== 1'b0 || head !== 4'd0) begin
            bad++; $display("FAIL ss_stop_wins got led=%h busy=%b head=%0d exp 0000 0 0", led, busy, head);
        end
        stop = 1'b0; start = 1'b0;
        cyc(3);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ss_stay_idle got busy=%b exp=0", busy); end
        arm(4'd9, 1'b0, 1'b0, 1'b0);
        total++; if (led !== 16'h0200 || head !== 4'd9) begin
            bad++; $display("FAIL ss_rearm got led=%h head=%0d exp 0200 9", led, head);
        end
        cyc(3);
        total++; if (led !== 16'h0200) begin bad++; $display("FAIL ss_phase_hold got=%h exp=0200", led); end
        cyc(1);
        total++; if (led !== 16'h0600) begin bad++; $display("FAIL ss_phase_tick got=%h exp=0600", led); end
        cyc(2);
        arm(4'd0, 1'b0, 1'b0, 1'b0);
        total++; if (led !== 16'h0001) begin bad++; $display("FAIL ss_run_rearm got=%h exp=0001", led); end
        cyc(3);
        total++; if (led !== 16'h0001) begin bad++; $display("FAIL ss_run_rearm_hold got=%h exp=0001", led); end
        cyc(1);
        total++; if (led !== 16'h0003) begin bad++; $display("FAIL ss_run_rearm_tick got=%h exp=0003", led); end
    endtask

    task automatic test_speed;
        arm(4'd0, 1'b0, 1'b0, 1'b0);
        cyc(3);
        total++; if (led !== 16'h0001) begin bad++; $display("FAIL spd_before got=%h exp=0001", led); end
        speed_sel = 1'b1;
        cyc(1);
        total++; if (led !== 16'h0003) begin bad++; $display("FAIL spd_switch_tick got=%h exp=0003", led); end
        cyc(1);
        total++; if (led !== 16'h0003) begin bad++; $display("FAIL spd_fast_hold got=%h exp=0003", led); end
        cyc(1);
        total++; if (led !== 16'h0007) begin bad++; $display("FAIL spd_fast_tick got=%h exp=0007", led); end
        speed_sel = 1'b0;
    endtask

    task automatic test_rst_mid_full;
        arm(4'd0, 1'b1, 1'b0, 1'b1);
        cyc(16);
        total++; if (led !== 16'hFFFF || busy !== 1'b1) begin
            bad++; $display("FAIL rf_full got led=%h busy=%b exp FFFF 1", led, busy);
        end
        rst = 1'b1;
        cyc(1);
        total++; if (led !== 16'h0000 || busy !== 1'b0 || head !== 4'd0 || wrap_pulse !== 1'b0) begin
            bad++; $display("FAIL rf_reset got led=%h busy=%b head=%0d wrap=%b exp 0000 0 0 0",
                            led, busy, head, wrap_pulse);
        end
        rst = 1'b0;
        cyc(2);
        total++; if (led !== 16'h0000 || busy !== 1'b0) begin
            bad++; $display("FAIL rf_after got led=%h busy=%b exp 0000 0", led, busy);
        end
    endtask

    initial begin
        test_reset();
        test_fill_step1();
        test_fill_step2();
        test_invert();
        test_stop_start();
        test_speed();
        test_rst_mid_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
